load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: sits between the CPU datapath (MEM stage) and the byte-addressed, big-endian data memory.
- Turns word, halfword and byte load/store requests into memory strobes.
- Performs read-modify-write for sub-word stores and sign- or zero-extends sub-word loads.
- Issues one access at a time, with a busy/done handshake toward the core.

Parameters:
- ADDR_W, 18, byte address width. Must match the memory's adress port.
- DATA_W, 32, data width. Fixed at 32; the byte-lane logic assumes 4 lanes.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req  input  1  request strobe; sampled at posedge only in IDLE
- we  input  1  1 = store, 0 = load
- size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- uns  input  1  zero-extend sub-word loads when 1, sign-extend when 0
- addr  input  ADDR_W  byte address
- wdata  input  32  store data; bytes taken from the low end (byte in [7:0], half in [15:0])
- rdata  output  32  load result; held until the next load completes
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse when a request completes
- err  output  1  valid with done; misaligned access
- mem_adress  output  ADDR_W  word-aligned address to memory (addr with [1:0] forced to 00)
- mem_write_data  output  32  full word to memory
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_read_data  input  32  memory read data; valid one posedge after mem_read

Behaviour:
- Reset (async): state=IDLE. rdata=0, done=0, err=0, mem_read=0, mem_write=0, mem_adress=0, mem_write_data=0.
  - Reset asserted mid-operation drops both strobes immediately.
  - No done is issued for the aborted request.
- Memory contract:
  - Read data is registered at the posedge where mem_read=1.
  - A write lands at the negedge within a cycle where mem_write=1.
  - Byte at offset 0 is bits [31:24].
- States: IDLE, RD, CAP, WR, FIN.
  - mem_read = (state==RD); mem_write = (state==WR).
  - IDLE + req: latch we/size/uns/addr/wdata.
    - misaligned -> FIN with err=1.
    - load or sub-word store -> RD.
    - word store -> WR.
  - RD -> CAP unconditionally.
  - CAP, load: rdata <= extracted lane, extended; -> FIN.
  - CAP, sub-word store: merge store lane(s) into mem_read_data and register into mem_write_data; -> WR.
  - WR -> FIN.
  - FIN: done=1 for exactly this cycle; -> IDLE.
- done and err are registered from the state, so they are high exactly while state==FIN.
- Latency from the req-sampling edge k, with done sampled high at edge:
  - misaligned: k+2
  - word store: k+3
  - load: k+4
  - sub-word store: k+5
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. No memory strobe is issued and rdata is unchanged.
- req while busy is ignored, not queued.
- Byte lane select: offset o drives bits [31-8o : 24-8o]. Half lane: offset 0 -> [31:16], offset 2 -> [15:0].
- Back-to-back: req may be high in the cycle after FIN (IDLE). There is no dead cycle beyond FIN.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misalignment is detected as above and reported via err.
- Undefined:
  - err is tied 0.
  - Misaligned addresses are truncated to their natural alignment (half: addr[0]=0; word: addr[1:0]=0).
  - The access proceeds normally.

Decomposition:
- Shared package lsu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state encoding (IDLE..FIN)
  - lane-index helper constants
- One combinational sub-module, lsu_lane_align:
  - inputs: word, offset, size, uns, store byte/half
  - outputs: extended load value and merged store word
- The FSM stays in load_store_unit.

Test Plan:
- Word store then load: store 0xDEADBEEF at addr 0x010, then load word at 0x010 -> mem_write pulse one cycle, rdata=0xDEADBEEF, done at k+3 and k+4 respectively.
- Byte store RMW: memory holds 0x11223344 at 0x020; store byte 0xAA at 0x021 -> memory word becomes 0x11AA3344, exactly one mem_read then one mem_write.
- Signed/unsigned sub-word loads from word 0x80FF7F01 at 0x030:
  - lb 0x030 -> 0xFFFFFF80
  - lbu 0x030 -> 0x00000080
  - lh 0x032 -> 0x00007F01
  - lhu 0x030 -> 0x000080FF
- Misaligned (macro defined): word load at 0x031 -> done with err=1 at k+2, no mem_read/mem_write, rdata unchanged. Macro undefined: same request reads word 0x030, err=0.
- Reset mid-op: assert reset while in WR -> mem_write low immediately, no done, state IDLE. After release, a fresh load completes normally.
- req held high while busy: extra requests are ignored. After FIN, the next sampled req starts exactly one new access.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - access size encodings (SZ_BYTE/SZ_HALF/SZ_WORD, SZ_RSVD behaves as word)
//   - FSM state encoding (IDLE, RD, CAP, WR, FIN)
//   - byte-lane constants and the offset-to-lane helper for the big-endian bus
package lsu_pkg;

    localparam int DATA_W    = 32;
    localparam int BYTE_W    = 8;
    localparam int NUM_LANES = DATA_W / BYTE_W;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        FIN  = 3'd4
    } state_e;

    // Halfword offsets within a word: offset 0 is the upper half on a big-endian bus.
    localparam logic [1:0] HALF_HI_OFF = 2'd0;
    localparam logic [1:0] HALF_LO_OFF = 2'd2;

    // Byte offset 0 lives in the most significant lane.
    function automatic logic [1:0] lane_idx(input logic [1:0] off);
        return 2'd3 - off;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Interfaces of the load/store unit.
//   lsu_core_if : core <-> LSU request/response (master = core, slave = LSU)
//                 req/we/size/uns/addr/wdata toward the LSU,
//                 rdata/busy/done/err back to the core.
//   lsu_mem_if  : LSU <-> data memory (master = LSU, slave = memory)
//                 mem_adress/mem_write_data/mem_read/mem_write toward memory,
//                 mem_read_data back (registered by the memory).
interface lsu_core_if #(parameter int ADDR_W = 18);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              busy;
    logic              done;
    logic              err;

    modport master (output req, we, size, uns, addr, wdata,
                    input  rdata, busy, done, err);
    modport slave  (input  req, we, size, uns, addr, wdata,
                    output rdata, busy, done, err);
endinterface

interface lsu_mem_if #(parameter int ADDR_W = 18);
    logic [ADDR_W-1:0] mem_adress;
    logic [31:0]       mem_write_data;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_read_data;

    modport master (output mem_adress, mem_write_data, mem_read, mem_write,
                    input  mem_read_data);
    modport slave  (input  mem_adress, mem_write_data, mem_read, mem_write,
                    output mem_read_data);
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for a 32-bit big-endian word.
//   word    : word read from memory
//   off     : byte offset within the word (already naturally aligned for size)
//   size    : access size (SZ_RSVD behaves as word)
//   uns     : zero-extend sub-word loads when 1, sign-extend when 0
//   st_data : store data, byte in [7:0], half in [15:0]
//   ld_val  : extracted and extended load value
//   st_word : word with the store lane(s) merged in (read-modify-write)
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  size_e       size,
    input  logic        uns,
    input  logic [15:0] st_data,
    output logic [31:0] ld_val,
    output logic [31:0] st_word
);

    logic [NUM_LANES-1:0][BYTE_W-1:0] lanes;
    logic [NUM_LANES-1:0][BYTE_W-1:0] merged;
    logic [7:0]                       b;
    logic [15:0]                      h;

    assign lanes = word;

    always_comb begin
        merged = lanes;
        b      = lanes[lane_idx(off)];
        h      = (off == HALF_LO_OFF) ? word[15:0] : word[31:16];
        ld_val = word;
        case (size)
            SZ_BYTE: begin
                ld_val                = uns ? {24'd0, b} : {{24{b[7]}}, b};
                merged[lane_idx(off)] = st_data[7:0];
            end
            SZ_HALF: begin
                ld_val = uns ? {16'd0, h} : {{16{h[15]}}, h};
                if (off == HALF_LO_OFF) merged[1:0] = st_data;
                else                    merged[3:2] = st_data;
            end
            default: ;
        endcase
        st_word = merged;
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the data-memory interface.
// Handles one byte/half/word load or store at a time: sub-word stores are done
// as read-modify-write, sub-word loads are sign/zero extended.
//   clk, reset : clock, asynchronous active-high reset
//   core       : lsu_core_if.slave  (req/we/size/uns/addr/wdata in; rdata/busy/done/err out)
//   mem        : lsu_mem_if.master  (word address, write data, read/write strobes; read data in)
// Config macro LSU_MISALIGN_TRAP_EN: when defined, misaligned accesses finish
// immediately with err=1 and no memory strobe; when undefined, err is 0 and the
// address is truncated to natural alignment.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    lsu_core_if.slave        core,
    lsu_mem_if.master        mem
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       mwdata_q, mwdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              we_q, we_d;
    size_e             size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        off_q, off_d;
    logic [15:0]       st_q, st_d;

    size_e             in_size;
    logic [1:0]        in_off;
    logic              mis_trap;
    logic              start;
    logic [31:0]       ld_val, st_word;

    // Reserved size collapses to word so the rest of the datapath sees three sizes.
    assign in_size = (size_e'(core.size) == SZ_RSVD) ? SZ_WORD : size_e'(core.size);
    assign start   = (state_q == IDLE) && core.req;

    // Offset truncated to natural alignment; with trapping enabled a misaligned
    // request never reaches the datapath, so the truncation is harmless there.
    always_comb begin
        case (in_size)
            SZ_BYTE: in_off = core.addr[1:0];
            SZ_HALF: in_off = {core.addr[1], 1'b0};
            default: in_off = 2'b00;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic err_q, err_d;

    assign mis_trap = ((in_size == SZ_HALF) && core.addr[0]) ||
                      ((in_size == SZ_WORD) && (core.addr[1:0] != 2'b00));
`else
    assign mis_trap = 1'b0;
`endif

    lsu_lane_align u_align (
        .word    (mem.mem_read_data),
        .off     (off_q),
        .size    (size_q),
        .uns     (uns_q),
        .st_data (st_q),
        .ld_val  (ld_val),
        .st_word (st_word)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (core.req) begin
                if (mis_trap)                            state_d = FIN;
                else if (!core.we || in_size != SZ_WORD) state_d = RD;
                else                                     state_d = WR;
            end
            RD:      state_d = CAP;
            CAP:     state_d = we_q ? WR : FIN;
            WR:      state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded straight from the state flop, so reset drops strobes at once.
    always_comb begin
        mem.mem_read  = (state_q == RD);
        mem.mem_write = (state_q == WR);
        core.done     = (state_q == FIN);
        core.busy     = (state_q != IDLE);
`ifdef LSU_MISALIGN_TRAP_EN
        core.err      = (state_q == FIN) && err_q;
`else
        core.err      = 1'b0;
`endif
    end

    // Datapath next values
    always_comb begin
        addr_d   = addr_q;
        mwdata_d = mwdata_q;
        rdata_d  = rdata_q;
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        off_d    = off_q;
        st_d     = st_q;
        if (start) begin
            addr_d = {core.addr[ADDR_W-1:2], 2'b00};
            we_d   = core.we;
            size_d = in_size;
            uns_d  = core.uns;
            off_d  = in_off;
            st_d   = core.wdata[15:0];
            // Word stores go straight to WR, so the full word is staged now.
            if (core.we && in_size == SZ_WORD && !mis_trap) mwdata_d = core.wdata;
        end else if (state_q == CAP) begin
            if (we_q) mwdata_d = st_word;
            else      rdata_d  = ld_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            mwdata_q <= '0;
            rdata_q  <= '0;
            we_q     <= 1'b0;
            size_q   <= SZ_BYTE;
            uns_q    <= 1'b0;
            off_q    <= 2'b00;
            st_q     <= '0;
        end else begin
            addr_q   <= addr_d;
            mwdata_q <= mwdata_d;
            rdata_q  <= rdata_d;
            we_q     <= we_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            off_q    <= off_d;
            st_q     <= st_d;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign err_d = start ? mis_trap : err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end
`endif

    assign mem.mem_adress     = addr_q;
    assign mem.mem_write_data = mwdata_q;
    assign core.rdata         = rdata_q;

endmodule
